// File: rtl/baud_gen_multi.sv
// baud_gen_multi: multi-rate UART baud generator built from a single divider chain.
//
// A divider counter (div_cnt) produces an oversampling tick. A second counter (os_cnt)
// counts OVERSAMPLE of those ticks per bit and produces a bit tick and a 50%-duty bit clock.
// Rate changes are deferred to a bit boundary, so no bit period or clock phase is ever cut short.
//
// Optional feature macro: BAUD_CUSTOM_DIV_EN
//   When defined, the input div_override is added. A non-zero value replaces the table divisor.
//   It is sampled only at an os-period wrap or while en=0.
//
// Ports:
//   src_clk      in   source clock; all logic runs on its rising edge
//   rst          in   asynchronous active-high reset
//   en           in   generator enable; counters and clock outputs are held at 0 when low
//   rate_sel     in   requested rate index (0..3 = 9600, 19200, 57600, 115200 baud)
//   div_override in   [BAUD_CUSTOM_DIV_EN only] non-zero divisor override
//   os_tick      out  one-cycle pulse at baud * OVERSAMPLE
//   baud_tick    out  one-cycle pulse at each bit boundary
//   Uart_clk     out  50%-duty clock at the baud rate; high in the first half of each bit
//   active_sel   out  rate index currently in effect
//   switch_busy  out  high while a requested rate change waits for a bit boundary
//   sel_err      out  one-cycle pulse when rate_sel moves to an out-of-range index

module baud_gen_multi #(
  parameter int unsigned SRC_CLK    = 50000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned NUM_RATES  = 4,
  parameter int unsigned SEL_W      = 2
) (
  input  logic             src_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] rate_sel,
`ifdef BAUD_CUSTOM_DIV_EN
  input  logic [DIV_W-1:0] div_override,
`endif
  output logic             os_tick,
  output logic             baud_tick,
  output logic             Uart_clk,
  output logic [SEL_W-1:0] active_sel,
  output logic             switch_busy,
  output logic             sel_err
);

  function automatic longint unsigned rate_of(input int idx);
    case (idx)
      0:       return 64'd9600;
      1:       return 64'd19200;
      2:       return 64'd57600;
      default: return 64'd115200;
    endcase
  endfunction

  // Rounded divisor for one table entry, never below 1.
  function automatic longint unsigned div_calc(input int idx);
    longint unsigned den;
    longint unsigned q;
    den = rate_of(idx) * 64'(OVERSAMPLE);
    q   = (64'(SRC_CLK) + den / 64'd2) / den;
    if (q == 64'd0) q = 64'd1;
    return q;
  endfunction

  localparam int unsigned OsW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0] OsHalf = OsW'(OVERSAMPLE / 2);

  if (OVERSAMPLE < 2 || (OVERSAMPLE % 2) != 0) begin : g_err_os
    $error("baud_gen_multi: OVERSAMPLE must be even and at least 2");
  end
  if (NUM_RATES < 1 || NUM_RATES > 4) begin : g_err_nr
    $error("baud_gen_multi: NUM_RATES must be 1..4");
  end
  if ((1 << SEL_W) < NUM_RATES) begin : g_err_sel
    $error("baud_gen_multi: SEL_W too narrow for NUM_RATES");
  end

  // Table padded to the full rate_sel range; unused slots mirror entry 0 and are never selected.
  logic [DIV_W-1:0] div_tab [1 << SEL_W];

  for (genvar i = 0; i < (1 << SEL_W); i++) begin : g_tab
    localparam int Idx = (i < int'(NUM_RATES)) ? i : 0;
    localparam longint unsigned DivVal = div_calc(Idx);
    if (DivVal >= (64'd1 << DIV_W)) begin : g_err_div
      $error("baud_gen_multi: DIV_W too narrow for divisor table");
    end
    assign div_tab[i] = DIV_W'(DivVal);
  end

  typedef enum logic {StIdle, StPending} sw_state_e;

  sw_state_e        state_q;
  logic [SEL_W-1:0] active_sel_q, pending_sel_q, pend_next;
  logic             switch_busy_q, sel_inv_q, sel_err_q;
  logic [DIV_W-1:0] div_cnt_q, div_cur;
  logic [OsW-1:0]   os_cnt_q;
  logic             os_tick_q, baud_tick_q, uart_clk_q;
  logic             sel_valid, os_wrap, bit_wrap;

  assign sel_valid = 32'(rate_sel) < NUM_RATES;

`ifdef BAUD_CUSTOM_DIV_EN
  logic [DIV_W-1:0] ovr_q;

  // Only picked up when a new os period starts, so a running period is never truncated.
  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      ovr_q <= '0;
    end else if (!en || os_wrap) begin
      ovr_q <= div_override;
    end
  end

  assign div_cur = (ovr_q != '0) ? ovr_q : div_tab[active_sel_q];
`else
  assign div_cur = div_tab[active_sel_q];
`endif

  // '>=' keeps the counter bounded even if the divisor ever shrinks under it.
  assign os_wrap  = div_cnt_q >= (div_cur - DIV_W'(1));
  assign bit_wrap = os_wrap && (os_cnt_q == OsLast);

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      div_cnt_q   <= '0;
      os_cnt_q    <= '0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      uart_clk_q  <= 1'b0;
    end else if (!en) begin
      div_cnt_q   <= '0;
      os_cnt_q    <= '0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      uart_clk_q  <= 1'b0;
    end else begin
      os_tick_q   <= os_wrap;
      baud_tick_q <= bit_wrap;
      uart_clk_q  <= os_cnt_q < OsHalf;
      if (os_wrap) begin
        div_cnt_q <= '0;
        os_cnt_q  <= (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
    end
  end

  // A valid new request while pending replaces the held one; invalid indices leave it alone.
  always_comb begin
    pend_next = pending_sel_q;
    if (sel_valid) pend_next = rate_sel;
  end

  // Rate switch FSM. The switch lands on the edge where the counters wrap at a bit
  // boundary, so the new divisor governs timing from the very next cycle.
  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      active_sel_q  <= '0;
      pending_sel_q <= '0;
      switch_busy_q <= 1'b0;
      sel_inv_q     <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      sel_inv_q <= !sel_valid;
      sel_err_q <= !sel_valid && !sel_inv_q;
      unique case (state_q)
        StIdle: begin
          if (sel_valid && (rate_sel != active_sel_q)) begin
            pending_sel_q <= rate_sel;
            switch_busy_q <= 1'b1;
            state_q       <= StPending;
          end
        end
        StPending: begin
          if (rate_sel == active_sel_q) begin
            switch_busy_q <= 1'b0;
            state_q       <= StIdle;
          end else if (bit_wrap || !en) begin
            active_sel_q  <= pend_next;
            switch_busy_q <= 1'b0;
            state_q       <= StIdle;
          end else begin
            pending_sel_q <= pend_next;
          end
        end
      endcase
    end
  end

  assign os_tick     = os_tick_q;
  assign baud_tick   = baud_tick_q;
  assign Uart_clk    = uart_clk_q;
  assign active_sel  = active_sel_q;
  assign switch_busy = switch_busy_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_baud_gen_multi.sv
// Directed bench for baud_gen_multi at SRC_CLK = 1843200 (divisors 12, 6, 2, 1).
// A second instance with NUM_RATES = 3 covers the out-of-range select path.
module tb_baud_gen_multi;

  localparam int unsigned SrcClk = 1843200;

  logic       src_clk = 1'b0;
  logic       rst, en, en_b;
  logic [1:0] rate_sel, rate_sel_b;
  logic       os_tick, baud_tick, uart_clk, switch_busy, sel_err;
  logic [1:0] active_sel;
  logic       os_tick_b, baud_tick_b, uart_clk_b, switch_busy_b, sel_err_b;
  logic [1:0] active_sel_b;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 src_clk = ~src_clk;

  baud_gen_multi #(
    .SRC_CLK(SrcClk), .OVERSAMPLE(16), .DIV_W(16), .NUM_RATES(4), .SEL_W(2)
  ) dut (
    .src_clk     (src_clk),
    .rst         (rst),
    .en          (en),
    .rate_sel    (rate_sel),
`ifdef BAUD_CUSTOM_DIV_EN
    .div_override(16'd0),
`endif
    .os_tick     (os_tick),
    .baud_tick   (baud_tick),
    .Uart_clk    (uart_clk),
    .active_sel  (active_sel),
    .switch_busy (switch_busy),
    .sel_err     (sel_err)
  );

  baud_gen_multi #(
    .SRC_CLK(SrcClk), .OVERSAMPLE(16), .DIV_W(16), .NUM_RATES(3), .SEL_W(2)
  ) dut_b (
    .src_clk     (src_clk),
    .rst         (rst),
    .en          (en_b),
    .rate_sel    (rate_sel_b),
`ifdef BAUD_CUSTOM_DIV_EN
    .div_override(16'd0),
`endif
    .os_tick     (os_tick_b),
    .baud_tick   (baud_tick_b),
    .Uart_clk    (uart_clk_b),
    .active_sel  (active_sel_b),
    .switch_busy (switch_busy_b),
    .sel_err     (sel_err_b)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles; sampling and driving happen 1 time unit after the rising edge.
  task automatic step(input int cyc);
    repeat (cyc) begin
      @(posedge src_clk);
      #1;
    end
  endtask

  // Cycles until the selected condition is seen (0 os_tick, 1 baud_tick, 2 Uart_clk high,
  // 3 Uart_clk low, 4 baud_tick of dut_b). Returns max_cyc if it never appears.
  task automatic wait_sig(input int which, input int max_cyc, output int cnt);
    logic hit;
    cnt = 0;
    hit = 1'b0;
    while (!hit && cnt < max_cyc) begin
      @(posedge src_clk);
      #1;
      cnt++;
      case (which)
        0:       hit = os_tick;
        1:       hit = baud_tick;
        2:       hit = uart_clk;
        3:       hit = !uart_clk;
        default: hit = baud_tick_b;
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; rate_sel = 2'd0; en_b = 1'b1; rate_sel_b = 2'd0;
    step(3);
    check_eq("rst_flags", int'({os_tick, baud_tick, uart_clk, switch_busy, sel_err}), 0);
    check_eq("rst_active", int'(active_sel), 0);

    // Rate 0: divisor 12, bit period 192.
    rst = 1'b0;
    wait_sig(2, 400, n); check_eq("uart_first_hi", n, 1);
    wait_sig(0, 400, n); check_eq("first_os", n, 11);
    wait_sig(0, 400, n); check_eq("os_period", n, 12);
    wait_sig(3, 400, n); check_eq("uart_first_fall", n, 73);
    wait_sig(1, 400, n); check_eq("first_baud", n, 95);
    wait_sig(2, 400, n); check_eq("uart_rise", n, 1);
    wait_sig(3, 400, n); check_eq("uart_hi_time", n, 96);
    wait_sig(2, 400, n); check_eq("uart_lo_time", n, 96);
    wait_sig(1, 400, n); check_eq("baud_after_rise", n, 191);
    wait_sig(1, 400, n); check_eq("baud_period0", n, 192);

    // Mid-bit switch to rate 2 (divisor 2, bit period 32).
    rate_sel = 2'd2;
    step(1);
    check_eq("sw_busy_set", int'(switch_busy), 1);
    check_eq("sw_active_old", int'(active_sel), 0);
    wait_sig(3, 400, n); check_eq("sw_old_fall", n, 96);
    wait_sig(1, 400, n); check_eq("sw_boundary", n, 95);
    check_eq("sw_active_new", int'(active_sel), 2);
    check_eq("sw_busy_clr", int'(switch_busy), 0);
    wait_sig(2, 400, n); check_eq("sw_uart_rise", n, 1);
    wait_sig(3, 400, n); check_eq("sw_uart_hi", n, 16);
    wait_sig(1, 400, n); check_eq("sw_baud_a", n, 15);
    wait_sig(1, 400, n); check_eq("baud_period2", n, 32);

    // Rate 3: divisor 1, os_tick every cycle.
    rate_sel = 2'd3;
    wait_sig(1, 400, n); check_eq("sw3_boundary", n, 32);
    check_eq("sw3_active", int'(active_sel), 3);
    wait_sig(0, 400, n); check_eq("div1_os_a", n, 1);
    wait_sig(0, 400, n); check_eq("div1_os_b", n, 1);
    wait_sig(1, 400, n); check_eq("div1_baud_a", n, 14);

    // Back to rate 0, then a request for 1 that is withdrawn before the boundary.
    rate_sel = 2'd0;
    wait_sig(1, 400, n); check_eq("sw0_boundary", n, 16);
    check_eq("sw0_active", int'(active_sel), 0);
    step(10);
    rate_sel = 2'd1;
    step(2);
    check_eq("cancel_busy_set", int'(switch_busy), 1);
    rate_sel = 2'd0;
    step(2);
    check_eq("cancel_busy_clr", int'(switch_busy), 0);
    wait_sig(1, 400, n); check_eq("cancel_baud", n, 178);
    wait_sig(1, 400, n); check_eq("cancel_period", n, 192);
    check_eq("cancel_active", int'(active_sel), 0);

    // Request lands on the same edge as a bit boundary: that tick stays at the old rate.
    step(191);
    rate_sel = 2'd3;
    wait_sig(1, 400, n); check_eq("simul_tick", n, 1);
    check_eq("simul_active_old", int'(active_sel), 0);
    check_eq("simul_busy", int'(switch_busy), 1);
    wait_sig(1, 400, n); check_eq("simul_next_bit", n, 192);
    check_eq("simul_active_new", int'(active_sel), 3);

    // Rate 1 (divisor 6), then asynchronous reset mid-bit.
    rate_sel = 2'd1;
    wait_sig(1, 400, n); check_eq("sw1_boundary", n, 16);
    check_eq("sw1_active", int'(active_sel), 1);
    step(40);
    check_eq("pre_rst_uart", int'(uart_clk), 1);
    rst = 1'b1;
    #2;
    check_eq("async_rst_flags", int'({os_tick, baud_tick, uart_clk, switch_busy, sel_err}), 0);
    check_eq("async_rst_active", int'(active_sel), 0);
    step(3);
    rst = 1'b0;
    wait_sig(0, 400, n); check_eq("post_rst_os", n, 12);
    check_eq("post_rst_active", int'(active_sel), 0);
    check_eq("post_rst_busy", int'(switch_busy), 1);

    // en=0 completes the pending switch at once and holds the outputs low.
    en = 1'b0;
    step(2);
    check_eq("en0_active", int'(active_sel), 1);
    check_eq("en0_busy", int'(switch_busy), 0);
    check_eq("en0_outs", int'({os_tick, baud_tick, uart_clk}), 0);
    en = 1'b1;
    wait_sig(0, 400, n); check_eq("en1_first_os", n, 6);

    // Out-of-range select on the three-rate instance.
    rate_sel_b = 2'd3;
    step(1);
    check_eq("b_sel_err_pulse", int'(sel_err_b), 1);
    step(1);
    check_eq("b_sel_err_once", int'(sel_err_b), 0);
    check_eq("b_active_kept", int'(active_sel_b), 0);
    rate_sel_b = 2'd1;
    step(1);
    check_eq("b_busy", int'(switch_busy_b), 1);
    rate_sel_b = 2'd3;
    step(1);
    check_eq("b_sel_err_again", int'(sel_err_b), 1);
    check_eq("b_pending_kept", int'(switch_busy_b), 1);
    wait_sig(4, 400, n); check_eq("b_boundary_seen", int'(n < 400), 1);
    check_eq("b_active_switched", int'(active_sel_b), 1);
    check_eq("b_busy_clr", int'(switch_busy_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
